mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single-port test memory between the core's instruction-fetch port and its load/store port. Uses round-robin fairness, converts sub-word stores into read-modify-write sequences, and provides one registered response per transaction. Also watches the 48-bit tohost word and raises sticky test-done/pass flags for the simulation harness. Sits between the core and the test memory model.

## Interface
- START_ADDR, 32'h8000_0000, base of the memory window
- TO_HOST_ADDR, 32'h8000_1000, tohost location (used only for documentation/asserts; value arrives on mem_tohost)
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch address; bits [1:0] ignored
- i_gnt  out  1  one-cycle pulse; request accepted and address latched
- i_rvalid  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address; bits [1:0] ignored (word-aligned access)
- d_wdata  in  32  store data, byte lanes already positioned
- d_wstrb  in  4  store byte enables; ignored for loads; 4'h0 store = no-op write that is still acknowledged
- d_gnt  out  1  one-cycle accept pulse
- d_rvalid  out  1  one-cycle pulse; load data valid or store complete
- d_rdata  out  32  loaded word (0 for stores)
- mem_addr  out  32  memory read address (combinational read into mem_rdata)
- mem_rdata  in  32  memory read word
- mem_we  out  1  memory write strobe, one cycle per write
- mem_waddr  out  32  memory write address, word-aligned
- mem_wdata  out  32  memory write word
- mem_tohost  in  48  tohost contents from memory
- test_done  out  1  sticky: tohost[0] seen set
- test_pass  out  1  sticky: valid only with test_done; tohost == 48'h1
- test_code  out  47  tohost[47:1] captured at done

## Operation
- States: IDLE, READ, RMW_RD, WRITE.
- IDLE: if exactly one req, grant it. If both, grant the requester not granted last (last_grant reg; reset value = DATA, so fetch wins the first tie). Grant pulses gnt, latches aligned addr, we, wdata, wstrb, and the source.
- Next state: fetch or load → READ; store with wstrb == 4'hF → WRITE; store with any other wstrb, including 4'h0 → RMW_RD.
- READ: mem_addr = latched addr. Register mem_rdata into the source's rdata. Pulse the source's rvalid next cycle. Go to IDLE.
- RMW_RD: mem_addr = latched addr. merge[8k+7:8k] = wstrb[k] ? wdata : mem_rdata per lane, registered. Go to WRITE.
- WRITE: mem_we = 1, mem_waddr = latched addr, mem_wdata = latched wdata (full) or merge (RMW). Go to IDLE. d_rvalid pulses next cycle.
- rvalid is a registered pulse coinciding with IDLE, so a new grant can occur in the same cycle as the previous response.
- mem_addr = 0 and mem_we = 0 outside READ/RMW_RD/WRITE.
- tohost monitor: when not done and mem_tohost[0] == 1, the next cycle sets test_done=1, test_pass = (mem_tohost[47:1]==0), and test_code = mem_tohost[47:1]. Held until rst.

## Timing
- Accept at cycle T:
  - read → rvalid at T+2
  - full store → mem_we at T+1, d_rvalid at T+2
  - partial store → read at T+1, mem_we at T+2, d_rvalid at T+3
- Maximum wait for a continuously requesting port is one other transaction (≤3 cycles).
- Reset values: all outputs 0; state IDLE; last_grant DATA.
- rst high in any cycle: mem_we forced 0 that cycle. In-flight transaction dropped with no rvalid and no gnt.
- Requester dropping req before gnt: no transaction occurs.

## Structure
- Package mem_arb_pkg: state enum, source enum {SRC_IFETCH, SRC_DATA}, START_ADDR/TO_HOST_ADDR constants.
- One sub-module: tohost_monitor (sticky done/pass/code logic).

## Test plan
- Lone fetch i_addr=0x8000_0004, memory word 0x00000013 → i_gnt at T, i_rvalid at T+2, i_rdata=0x00000013.
- i_req and d_req (load) both raised from reset → fetch granted first, data granted in the cycle of i_rvalid, d_rvalid 2 cycles later. Both held high continuously → grants alternate.
- Store d_addr=0x8000_0100, wstrb=4'hF, wdata=0xDEADBEEF → single mem_we at T+1, waddr 0x8000_0100. Subsequent load returns 0xDEADBEEF.
- Word 0x11223344, store wstrb=4'b0010, wdata=0x0000AA00 → mem_we at T+2 with 0x1122AA44, d_rvalid at T+3.
- rst asserted in the WRITE cycle of a store → mem_we stays 0, no d_rvalid, memory unchanged, outputs 0 next cycle.
- Two tohost cases:
  - mem_tohost=48'h1 → next cycle test_done=1, test_pass=1.
  - mem_tohost=48'h7 → test_pass=0, test_code=3; flags stay set after tohost cleared.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the test-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STRB_W   = XLEN / 8;
  localparam int unsigned TOHOST_W = 48;
  localparam int unsigned CODE_W   = TOHOST_W - 1;

  localparam logic [XLEN-1:0] START_ADDR   = 32'h8000_0000;
  localparam logic [XLEN-1:0] TO_HOST_ADDR = 32'h8000_1000;
  localparam logic [XLEN-1:0] WORD_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW_RD,
    ST_WRITE
  } state_t;

  typedef enum logic {
    SRC_IFETCH,
    SRC_DATA
  } src_t;

  // Transaction captured at grant time
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
    src_t              src;
  } txn_t;

  // Byte-lane merge: enabled lanes from new data, the rest from the old word
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]   new_word,
                                                  input logic [XLEN-1:0]   old_word,
                                                  input logic [STRB_W-1:0] strb);
    logic [XLEN-1:0] r;
    r = old_word;
    for (int k = 0; k < int'(STRB_W); k++) begin
      if (strb[k]) r[8*k +: 8] = new_word[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_tohost_monitor.sv
// Sticky test-done/pass/code capture from the tohost word.
module tohost_monitor
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [TOHOST_W-1:0] tohost,
  output logic                done,
  output logic                pass,
  output logic [CODE_W-1:0]   code
);

  // First tohost write with bit 0 set latches the result until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      pass <= 1'b0;
      code <= '0;
    end else if (!done && tohost[0]) begin
      done <= 1'b1;
      pass <= (tohost[TOHOST_W-1:1] == '0);
      code <= tohost[TOHOST_W-1:1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between fetch and load/store ports onto a single-port
// memory; sub-word stores become read-modify-write sequences.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [XLEN-1:0]     i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [XLEN-1:0]     i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [XLEN-1:0]     d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  input  logic [STRB_W-1:0]   d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [XLEN-1:0]     d_rdata,
  output logic [XLEN-1:0]     mem_addr,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_waddr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [TOHOST_W-1:0] mem_tohost,
  output logic                test_done,
  output logic                test_pass,
  output logic [CODE_W-1:0]   test_code
);

  state_t          state_q, state_d;
  src_t            last_grant_q, last_grant_d;
  txn_t            txn_q, txn_d;
  logic [XLEN-1:0] merge_q, merge_d;
  logic            grant_i, grant_d;

  // State and arbitration history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_DATA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state, grants and memory-side strobes
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    txn_d        = txn_q;
    merge_d      = merge_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_IDLE: begin
        // Ties go to whichever port was not served last
        grant_i = i_req && (!d_req || (last_grant_q == SRC_DATA));
        grant_d = d_req && !grant_i;
        if (grant_i) begin
          txn_d.addr   = i_addr & WORD_MASK;
          txn_d.wdata  = '0;
          txn_d.wstrb  = '0;
          txn_d.src    = SRC_IFETCH;
          last_grant_d = SRC_IFETCH;
          state_d      = ST_READ;
        end else if (grant_d) begin
          txn_d.addr   = d_addr & WORD_MASK;
          txn_d.wdata  = d_wdata;
          txn_d.wstrb  = d_wstrb;
          txn_d.src    = SRC_DATA;
          last_grant_d = SRC_DATA;
          if (!d_we)          state_d = ST_READ;
          else if (&d_wstrb)  state_d = ST_WRITE;
          else                state_d = ST_RMW_RD;
        end
      end
      ST_READ: begin
        mem_addr = txn_q.addr;
        state_d  = ST_IDLE;
      end
      ST_RMW_RD: begin
        mem_addr = txn_q.addr;
        merge_d  = merge_bytes(txn_q.wdata, mem_rdata, txn_q.wstrb);
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_waddr = txn_q.addr;
        mem_wdata = (&txn_q.wstrb) ? txn_q.wdata : merge_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset aborts the cycle: no accept and no memory write
    if (rst) begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      mem_we  = 1'b0;
    end
    i_gnt = grant_i;
    d_gnt = grant_d;
  end

  // Latched transaction and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_q    <= '0;
      merge_q  <= '0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      txn_q    <= txn_d;
      merge_q  <= merge_d;
      i_rvalid <= (state_q == ST_READ) && (txn_q.src == SRC_IFETCH);
      d_rvalid <= ((state_q == ST_READ) && (txn_q.src == SRC_DATA)) || (state_q == ST_WRITE);
      if ((state_q == ST_READ) && (txn_q.src == SRC_IFETCH)) i_rdata <= mem_rdata;
      if ((state_q == ST_READ) && (txn_q.src == SRC_DATA))   d_rdata <= mem_rdata;
      if (state_q == ST_WRITE)                                d_rdata <= '0;
    end
  end

  tohost_monitor u_tohost_monitor (
    .clk    (clk),
    .rst    (rst),
    .tohost (mem_tohost),
    .done   (test_done),
    .pass   (test_pass),
    .code   (test_code)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses and
// writes, a negedge monitor pops and compares data and arrival cycle.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic [31:0] mem_addr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_we;
  logic [47:0] mem_tohost;
  logic        test_done, test_pass;
  logic [46:0] test_code;

  logic [31:0] tb_mem [0:1023];
  logic        pre_we;
  logic [31:0] pre_addr, pre_data;

  exp_t  iq[$], dq[$];
  wexp_t wq[$];
  exp_t  ie, de;
  wexp_t we_e;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_tohost (mem_tohost),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .test_code  (test_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, one write port shared with preload
  assign mem_rdata = tb_mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_we)      tb_mem[mem_waddr[11:2]] <= mem_wdata;
    else if (pre_we) tb_mem[pre_addr[11:2]]  <= pre_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response or write must match the head of its queue
  always @(negedge clk) begin
    if (i_rvalid) begin
      if (iq.size() == 0) check("unexpected_i_rvalid", 64'(i_rvalid), 64'd0);
      else begin
        ie = iq.pop_front();
        check("i_rdata", 64'(i_rdata), 64'(ie.data));
        check("i_rvalid_cycle", 64'(cyc), 64'(ie.due));
      end
    end
    if (d_rvalid) begin
      if (dq.size() == 0) check("unexpected_d_rvalid", 64'(d_rvalid), 64'd0);
      else begin
        de = dq.pop_front();
        check("d_rdata", 64'(d_rdata), 64'(de.data));
        check("d_rvalid_cycle", 64'(cyc), 64'(de.due));
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) check("unexpected_mem_we", 64'(mem_we), 64'd0);
      else begin
        we_e = wq.pop_front();
        check("mem_waddr", 64'(mem_waddr), 64'(we_e.addr));
        check("mem_wdata", 64'(mem_wdata), 64'(we_e.data));
        check("mem_we_cycle", 64'(cyc), 64'(we_e.due));
      end
    end
  end

  task automatic pre_write(input logic [31:0] addr, input logic [31:0] data);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the posedge ending the grant cycle
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data, output int g);
    bit got = 1'b0;
    g = -1;
    i_req = 1'b1; i_addr = addr;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (i_gnt) begin got = 1'b1; g = cyc; end
    end
    check("fetch_gnt_seen", 64'(got), 64'd1);
    if (got) iq.push_back('{data: exp_data, due: g + 2});
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_data, output int g);
    bit got = 1'b0;
    g = -1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1'b1; g = cyc; end
    end
    check("data_gnt_seen", 64'(got), 64'd1);
    if (got) begin
      if (!we) dq.push_back('{data: exp_data, due: g + 2});
      else if (strb == 4'hF) begin
        wq.push_back('{addr: addr & 32'hFFFF_FFFC, data: exp_data, due: g + 1});
        dq.push_back('{data: 32'h0, due: g + 2});
      end else begin
        wq.push_back('{addr: addr & 32'hFFFF_FFFC, data: exp_data, due: g + 2});
        dq.push_back('{data: 32'h0, due: g + 3});
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa [3];
    logic [31:0] fe [3];
    logic [31:0] la [3];
    logic [31:0] le [3];
    int gi [3];
    int gd [3];
    int g, t0;

    fa[0] = 32'h8000_0004; fe[0] = 32'h0000_0013;
    fa[1] = 32'h8000_0008; fe[1] = 32'h0000_0093;
    fa[2] = 32'h8000_000C; fe[2] = 32'h0010_0073;
    la[0] = 32'h8000_0110; le[0] = 32'hA5A5_A5A5;
    la[1] = 32'h8000_0114; le[1] = 32'h1234_5678;
    la[2] = 32'h8000_0112; le[2] = 32'hA5A5_A5A5;

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_tohost = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    pre_write(32'h8000_0004, 32'h0000_0013);
    pre_write(32'h8000_0008, 32'h0000_0093);
    pre_write(32'h8000_000C, 32'h0010_0073);
    pre_write(32'h8000_0110, 32'hA5A5_A5A5);
    pre_write(32'h8000_0114, 32'h1234_5678);
    pre_write(32'h8000_0140, 32'h1122_3344);
    pre_write(32'h8000_0200, 32'h5555_5555);

    // Reset state
    @(negedge clk);
    check("rst_i_gnt", 64'(i_gnt), 64'd0);
    check("rst_i_rvalid", 64'(i_rvalid), 64'd0);
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_test_done", 64'(test_done), 64'd0);
    check("rst_test_code", 64'(test_code), 64'd0);

    // Both ports from reset, held continuously: fetch first, then alternate
    @(posedge clk); #1;
    rst = 1'b0;
    t0 = cyc;
    fork
      begin for (int k = 0; k < 3; k++) do_fetch(fa[k], fe[k], gi[k]); end
      begin for (int k = 0; k < 3; k++) do_data(1'b0, la[k], 32'h0, 4'h0, le[k], gd[k]); end
    join
    check("tie_fetch_first_cycle", 64'(gi[0]), 64'(t0));
    for (int k = 0; k < 3; k++) check("alt_data_after_fetch", 64'(gd[k]), 64'(gi[k] + 2));
    for (int k = 0; k < 2; k++) check("alt_fetch_after_data", 64'(gi[k + 1]), 64'(gd[k] + 2));
    idle(4);

    // Lone fetch granted in the cycle it is raised
    t0 = cyc;
    do_fetch(32'h8000_0004, 32'h0000_0013, g);
    check("lone_fetch_gnt_cycle", 64'(g), 64'(t0));

    // Request withdrawn while busy never gets a grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0110;
    @(negedge clk);
    check("dropped_req_no_gnt", 64'(d_gnt), 64'd0);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check("dropped_req_still_no_gnt", 64'(d_gnt), 64'd0);
    idle(4);

    // Full-word store, then read back
    do_data(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, g);
    do_data(1'b0, 32'h8000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, g);
    idle(3);

    // Sub-word stores become read-modify-write
    do_data(1'b1, 32'h8000_0140, 32'h0000_AA00, 4'b0010, 32'h1122_AA44, g);
    do_data(1'b0, 32'h8000_0140, 32'h0, 4'h0, 32'h1122_AA44, g);
    do_data(1'b1, 32'h8000_0141, 32'h7700_0088, 4'b1001, 32'h7722_AA88, g);
    do_data(1'b1, 32'h8000_0140, 32'hFFFF_FFFF, 4'b0000, 32'h7722_AA88, g);
    do_data(1'b0, 32'h8000_0140, 32'h0, 4'h0, 32'h7722_AA88, g);
    idle(5);
    check("queues_drained_mid", 64'(iq.size() + dq.size() + wq.size()), 64'd0);

    // Reset during the write cycle of a store drops it
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0200; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF;
    @(negedge clk);
    check("rst_store_gnt", 64'(d_gnt), 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_write_mem_we", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_d_rvalid", 64'(d_rvalid), 64'd0);
    check("post_rst_i_rdata", 64'(i_rdata), 64'd0);
    check("post_rst_mem_we", 64'(mem_we), 64'd0);
    check("post_rst_mem_addr", 64'(mem_addr), 64'd0);
    idle(4);
    check("rst_store_mem_unchanged", 64'(tb_mem[10'h080]), 64'h5555_5555);

    // tohost == 1: pass
    mem_tohost = 48'h1;
    @(negedge clk);
    check("tohost1_not_yet_done", 64'(test_done), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("tohost1_done", 64'(test_done), 64'd1);
    check("tohost1_pass", 64'(test_pass), 64'd1);
    check("tohost1_code", 64'(test_code), 64'd0);

    rst = 1'b1;
    mem_tohost = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("tohost_cleared_by_rst", 64'(test_done), 64'd0);

    // tohost == 7: fail with code 3, sticky after tohost clears
    @(posedge clk); #1;
    mem_tohost = 48'h7;
    @(posedge clk); #1;
    mem_tohost = '0;
    @(negedge clk);
    check("tohost7_done", 64'(test_done), 64'd1);
    check("tohost7_pass", 64'(test_pass), 64'd0);
    check("tohost7_code", 64'(test_code), 64'd3);
    idle(3);
    @(negedge clk);
    check("tohost7_done_sticky", 64'(test_done), 64'd1);
    check("tohost7_code_sticky", 64'(test_code), 64'd3);

    check("queues_drained_end", 64'(iq.size() + dq.size() + wq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
